// File: rtl/proc_pkg.sv
// Shared types for the memory responder: phase codes reported to the core
// and the two-step beat sequence used while streaming data memory out.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DUMP = 2'b10,
    ST_DONE = 2'b11
  } status_t;

  typedef enum logic {
    PH_RD   = 1'b0,
    PH_SHOW = 1'b1
  } dump_ph_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM, read-first: a read and a write to the same
// address on one edge return the previously stored word.
module mem_bank #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [0:(1<<AW)-1];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // NOTE: the storage array is deliberately left out of reset; contents
  // survive rst and the array maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: owns data and instruction memory and sequences the
// system through LOAD, RUN, DUMP and DONE.
module mem_responder
  import proc_pkg::*;
#(
  parameter int DM_AW = 8,
  parameter int IM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_sel,
  input  logic [15:0]      ld_addr,
  input  logic [15:0]      ld_data,
  input  logic             ld_last,
  input  logic [15:0]      dar_out,
  input  logic [15:0]      pc_out,
  input  logic [15:0]      bus_out,
  input  logic             dm_en,
  input  logic             im_en,
  input  logic             end_process,
  output logic [7:0]       dm_out,
  output logic [15:0]      im_out,
  output logic [1:0]       status,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [DM_AW-1:0] dump_addr,
  output logic [7:0]       dump_data,
  output logic             dump_last
);

  status_t          status_q, status_d;
  dump_ph_t         ph_q, ph_d;
  logic [DM_AW-1:0] cnt_q, cnt_d;
  logic             dump_valid_q, dump_valid_d;
  logic             ld_ready_q, ld_ready_d;

  logic             ld_fire;
  logic             dump_fire;
  logic             cnt_last;

  logic             dm_re, dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [7:0]       dm_wdata, dm_rdata;
  logic             im_re, im_we;
  logic [IM_AW-1:0] im_addr;
  logic [15:0]      im_wdata, im_rdata;

  // High address bits beyond the memory depth are dropped on purpose.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{ld_addr, dar_out, pc_out};

  assign ld_fire   = ld_valid && ld_ready_q;
  assign dump_fire = dump_valid_q && dump_ready;
  assign cnt_last  = &cnt_q;

  always_comb begin
    status_d     = status_q;
    ph_d         = ph_q;
    cnt_d        = cnt_q;
    dump_valid_d = dump_valid_q;
    unique case (status_q)
      ST_LOAD: begin
        if (ld_fire && ld_last) status_d = ST_RUN;
      end
      ST_RUN: begin
        if (end_process) begin
          status_d     = ST_DUMP;
          ph_d         = PH_RD;
          cnt_d        = '0;
          dump_valid_d = 1'b0;
        end
      end
      ST_DUMP: begin
        if (ph_q == PH_RD) begin
          ph_d         = PH_SHOW;
          dump_valid_d = 1'b1;
        end else if (dump_fire) begin
          ph_d         = PH_RD;
          dump_valid_d = 1'b0;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_last) status_d = ST_DONE;
        end
      end
      default: ;
    endcase
    ld_ready_d = (status_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q     <= ST_LOAD;
      ph_q         <= PH_RD;
      cnt_q        <= '0;
      dump_valid_q <= 1'b0;
      ld_ready_q   <= 1'b0;
    end else begin
      status_q     <= status_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      dump_valid_q <= dump_valid_d;
      ld_ready_q   <= ld_ready_d;
    end
  end

  // Port ownership follows the phase: loader, then core, then dump reader.
  always_comb begin
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = cnt_q;
    dm_wdata = '0;
    im_re    = 1'b0;
    im_we    = 1'b0;
    im_addr  = '0;
    im_wdata = '0;
    unique case (status_q)
      ST_LOAD: begin
        dm_we    = ld_fire && !ld_sel;
        dm_addr  = ld_addr[DM_AW-1:0];
        dm_wdata = ld_data[7:0];
        im_we    = ld_fire && ld_sel;
        im_addr  = ld_addr[IM_AW-1:0];
        im_wdata = ld_data;
      end
      ST_RUN: begin
        dm_re    = 1'b1;
        dm_we    = dm_en;
        dm_addr  = dar_out[DM_AW-1:0];
        dm_wdata = bus_out[7:0];
        im_re    = 1'b1;
        im_we    = im_en;
        im_addr  = pc_out[IM_AW-1:0];
        im_wdata = bus_out;
      end
      ST_DUMP: begin
        dm_re = (ph_q == PH_RD);
      end
      default: ;
    endcase
    // A reset cycle must never disturb memory contents.
    if (rst) begin
      dm_we = 1'b0;
      im_we = 1'b0;
    end
  end

  mem_bank #(.W(8), .AW(DM_AW)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .re    (dm_re),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  mem_bank #(.W(16), .AW(IM_AW)) u_imem (
    .clk   (clk),
    .rst   (rst),
    .re    (im_re),
    .we    (im_we),
    .addr  (im_addr),
    .wdata (im_wdata),
    .rdata (im_rdata)
  );

  assign status     = status_q;
  assign ld_ready   = ld_ready_q;
  assign dm_out     = dm_rdata;
  assign im_out     = im_rdata;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = cnt_q;
  assign dump_data  = dump_valid_q ? dm_rdata : 8'h00;
  assign dump_last  = dump_valid_q && cnt_last;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a cycle-level phase/memory model checked every
// negative edge, plus directed literal expectations from the test plan.
module tb_mem_responder;

  localparam int DM_AW = 8;
  localparam int IM_AW = 8;
  localparam int DM_D  = 1 << DM_AW;
  localparam int IM_D  = 1 << IM_AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_valid, ld_sel, ld_last;
  logic [15:0]      ld_addr, ld_data;
  logic             ld_ready;
  logic [15:0]      dar_out, pc_out, bus_out;
  logic             dm_en, im_en, end_process;
  logic [7:0]       dm_out;
  logic [15:0]      im_out;
  logic [1:0]       status;
  logic             dump_valid, dump_ready, dump_last;
  logic [DM_AW-1:0] dump_addr;
  logic [7:0]       dump_data;

  always #5 clk = ~clk;

  mem_responder #(.DM_AW(DM_AW), .IM_AW(IM_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_sel      (ld_sel),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .dar_out     (dar_out),
    .pc_out      (pc_out),
    .bus_out     (bus_out),
    .dm_en       (dm_en),
    .im_en       (im_en),
    .end_process (end_process),
    .dm_out      (dm_out),
    .im_out      (im_out),
    .status      (status),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_last   (dump_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  dm_m [DM_D];
  logic [15:0] im_m [IM_D];
  int          m_phase = 0;
  int          m_idx   = 0;
  logic        m_ld_rdy = 1'b0;
  logic        m_dv     = 1'b0;
  logic [7:0]  m_dmo    = 8'h00;
  logic [15:0] m_imo    = 16'h0000;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      m_phase    = 0;
      m_idx      = 0;
      m_ld_rdy   = 1'b0;
      m_dv       = 1'b0;
      m_dmo      = 8'h00;
      m_imo      = 16'h0000;
    end else if (model_live) begin
      case (m_phase)
        0: if (ld_valid && m_ld_rdy) begin
             if (ld_sel) im_m[int'(ld_addr) % IM_D] = ld_data;
             else        dm_m[int'(ld_addr) % DM_D] = ld_data[7:0];
             if (ld_last) m_phase = 1;
           end
        1: begin
             m_dmo = dm_m[int'(dar_out) % DM_D];
             m_imo = im_m[int'(pc_out) % IM_D];
             if (dm_en) dm_m[int'(dar_out) % DM_D] = bus_out[7:0];
             if (im_en) im_m[int'(pc_out) % IM_D]  = bus_out;
             if (end_process) begin
               m_phase = 2;
               m_idx   = 0;
               m_dv    = 1'b0;
             end
           end
        2: if (!m_dv) m_dv = 1'b1;
           else if (dump_ready) begin
             m_dv = 1'b0;
             if (m_idx == DM_D - 1) m_phase = 3;
             m_idx = (m_idx + 1) % DM_D;
           end
        default: ;
      endcase
      m_ld_rdy = (m_phase == 0);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("status", 32'(status), 32'(m_phase));
      check("ld_ready", 32'(ld_ready), 32'(m_ld_rdy));
      check("dump_valid", 32'(dump_valid), 32'(m_dv));
      check("dump_addr", 32'(dump_addr), 32'(m_idx));
      check("dump_last", 32'(dump_last), 32'(m_dv && m_idx == DM_D - 1));
      check("dump_data", 32'(dump_data), m_dv ? 32'(dm_m[m_idx]) : 32'h0);
      if (m_phase < 2 && !$isunknown(m_dmo)) check("dm_out", 32'(dm_out), 32'(m_dmo));
      if (m_phase < 2 && !$isunknown(m_imo)) check("im_out", 32'(im_out), 32'(m_imo));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_status(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (status !== s && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(status), 32'(s));
  endtask

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 7 + 3) & 8'hFF);
  endfunction

  task automatic load_last_beat();
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 16'h0009; ld_data = 16'h0909; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("reload_run", 32'(status), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  saw_last;
    rst = 1'b1;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    dar_out = '0; pc_out = '0; bus_out = '0;
    dm_en = 1'b0; im_en = 1'b0; end_process = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    check("rst_status", 32'(status), 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h0);
    check("rst_dump_valid", 32'(dump_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("load_ready", 32'(ld_ready), 32'h1);

    // end_process and core strobes are ignored in LOAD
    end_process = 1'b1; dm_en = 1'b1; dar_out = 16'h0005; bus_out = 16'h0099;
    tick();
    end_process = 1'b0; dm_en = 1'b0;
    check("ep_in_load", 32'(status), 32'h0);

    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 16'h0000; ld_data = 16'h1234; ld_last = 1'b0;
    tick();
    ld_sel = 1'b0; ld_addr = 16'h0005; ld_data = 16'h00A5; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("run_status", 32'(status), 32'h1);
    check("run_ld_ready", 32'(ld_ready), 32'h0);

    pc_out = 16'h0000; dar_out = 16'h0005;
    tick();
    check("im_read", 32'(im_out), 32'h1234);
    check("dm_read", 32'(dm_out), 32'hA5);

    dm_en = 1'b1; bus_out = 16'h003C;
    tick();
    dm_en = 1'b0;
    check("read_first_old", 32'(dm_out), 32'hA5);
    tick();
    check("read_first_new", 32'(dm_out), 32'h3C);

    dar_out = 16'h0105;
    tick();
    check("addr_wrap", 32'(dm_out), 32'h3C);

    // loader ignored in RUN
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 16'h0005; ld_data = 16'h00FF; ld_last = 1'b1;
    dar_out = 16'h0005;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("ld_in_run", 32'(dm_out), 32'h3C);
    check("ld_in_run_status", 32'(status), 32'h1);

    im_en = 1'b1; pc_out = 16'h0003; bus_out = 16'hBEEF;
    tick();
    im_en = 1'b0;
    tick();
    check("im_write", 32'(im_out), 32'hBEEF);

    for (int i = 0; i < DM_D; i++) begin
      dm_en = 1'b1; dar_out = 16'(i); bus_out = {8'h00, pattern(i)};
      tick();
    end

    end_process = 1'b1; dm_en = 1'b1; dar_out = 16'h0000; bus_out = 16'h0077;
    tick();
    end_process = 1'b0; dm_en = 1'b0;
    check("dump_status", 32'(status), 32'h2);
    check("dump_first_idle", 32'(dump_valid), 32'h0);
    tick();
    check("beat0_valid", 32'(dump_valid), 32'h1);
    check("beat0_addr", 32'(dump_addr), 32'h0);
    check("beat0_data", 32'(dump_data), 32'h77);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", 32'(dump_valid), 32'h1);
      check("stall_data", 32'(dump_data), 32'h77);
    end
    dump_ready = 1'b1;
    n = 0; saw_last = 1'b0;
    while (status !== 2'b11 && n < 2000) begin
      if (dump_valid && dump_last) begin
        saw_last = 1'b1;
        check("last_addr", 32'(dump_addr), 32'hFF);
      end
      tick();
      n++;
    end
    check("saw_last", 32'(saw_last), 32'h1);
    check("done_status", 32'(status), 32'h3);
    check("done_valid", 32'(dump_valid), 32'h0);
    tick();
    check("done_ld_ready", 32'(ld_ready), 32'h0);

    // second run: reset during SHOW of beat 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_last_beat();
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    n = 0;
    while (!(dump_valid && dump_addr == 8'd10) && n < 200) begin
      tick();
      n++;
    end
    check("beat10_reached", 32'(dump_addr), 32'd10);
    check("beat10_data", 32'(dump_data), 32'h49);
    dump_ready = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_status", 32'(status), 32'h0);
    check("mid_rst_valid", 32'(dump_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("mid_rst_ld_ready", 32'(ld_ready), 32'h1);

    // third run: memory survived the reset
    load_last_beat();
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    dump_ready = 1'b1;
    n = 0;
    while (status !== 2'b11 && n < 2000) begin
      if (dump_valid && dump_addr == 8'd0)  check("kept_addr0", 32'(dump_data), 32'h77);
      if (dump_valid && dump_addr == 8'd10) check("kept_addr10", 32'(dump_data), 32'h49);
      tick();
      n++;
    end
    wait_status(2'b11, 10, "final_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor core. It owns the 8-bit data memory and the 16-bit instruction memory. It drives `dm_out`, `im_out` and `status` back to the core, and services the core's `dm_en`/`im_en` writes. It sequences the system through three phases:

- **LOAD**: an external loader fills both memories.
- **RUN**: the core executes against the memories.
- **DUMP**: after `end_process`, data memory is streamed out.

## Interface
Parameters:
- `DM_AW`, default 8: data-memory address bits. Depth is 2^DM_AW bytes.
- `IM_AW`, default 8: instruction-memory address bits. Depth is 2^IM_AW words.

Ports:
- `clk` in 1: single clock. All logic acts on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_valid` in 1: loader write request.
- `ld_ready` out 1: loader may write. High only in LOAD.
- `ld_sel` in 1: 0 selects dmem, 1 selects imem.
- `ld_addr` in 16: loader address. Only the low DM_AW/IM_AW bits are used.
- `ld_data` in 16: loader data. Only bits [7:0] are used for dmem.
- `ld_last` in 1: marks the final load beat.
- `dar_out` in 16: core data address.
- `pc_out` in 16: core instruction address.
- `bus_out` in 16: core write data.
- `dm_en` in 1: core dmem write strobe.
- `im_en` in 1: core imem write strobe.
- `end_process` in 1: core finished.
- `dm_out` out 8: registered dmem read data.
- `im_out` out 16: registered imem read data.
- `status` out 2: phase code. 00 = LOAD, 01 = RUN, 10 = DUMP, 11 = DONE.
- `dump_valid` out 1: dump beat valid.
- `dump_ready` in 1: dump consumer accepts the beat.
- `dump_addr` out DM_AW: address of the current dump beat.
- `dump_data` out 8: dmem byte at `dump_addr`.
- `dump_last` out 1: high on the beat for address 2^DM_AW−1.

## Operation
- **Reset** (any state): go to LOAD. All outputs reset to 0 (`status`=00, `ld_ready`=0, `dm_out`=0, `im_out`=0, all dump outputs 0). Memory contents are not cleared.
- **LOAD**:
  - `ld_ready`=1 from the first cycle after reset deasserts.
  - A write occurs on an edge with `ld_valid` && `ld_ready`.
  - Accepting a beat with `ld_last`=1 moves the block to RUN on the next cycle. That beat is still written.
  - `dm_en`, `im_en` and `end_process` are ignored in LOAD.
- **RUN**:
  - Every cycle: `dm_out` <= dmem[`dar_out`], `im_out` <= imem[`pc_out`].
  - `dm_en`=1 writes dmem[`dar_out`] <= `bus_out[7:0]`.
  - `im_en`=1 writes imem[`pc_out`] <= `bus_out`.
  - Read-during-write to the same address returns the old data (read-first).
  - `ld_*` inputs are ignored in RUN.
- **RUN to DUMP**: `end_process`=1 moves the block to DUMP on the next cycle. A write strobe asserted in that same cycle is still performed.
- **DUMP**:
  - The address counter starts at 0.
  - Each beat is two phases:
    1. RD: one cycle, issues the RAM read.
    2. SHOW: `dump_valid`=1, with `dump_data` and `dump_addr` held stable until `dump_ready`.
  - On handshake the counter increments and the block returns to RD.
  - Handshake on the `dump_last` beat moves the block to DONE.
- **DONE**: terminal state with `status`=11. `dump_valid`=0 and `ld_ready`=0. Only `rst` leaves DONE.
- **Address width**: all addresses are truncated to their low bits, so out-of-range addresses wrap.

## Timing
- `status` is registered and changes one cycle after the triggering edge.
- Core read latency is 1 cycle: an address presented at edge N produces data valid after edge N. This matches the core's registered-strobe convention.
- Writes take effect at the edge where the strobe is sampled.
- Dump throughput is one byte per 2 cycles when `dump_ready` is held high.
- Dump latency from entering DUMP to the first `dump_valid` is 1 cycle.
- The dump takes 2·2^DM_AW cycles minimum.
- `dump_valid` must not drop without a handshake, and `dump_data` must not change while `dump_valid`=1 && !`dump_ready`.
- `rst` in the middle of a DUMP beat drops `dump_valid` on the next cycle.

## Structure
- Package `proc_pkg` holds:
  - the `status_t` enum (LOAD/RUN/DUMP/DONE, 2 bits);
  - the `dump_ph_t` enum (RD/SHOW).
- Sub-module `mem_bank`: a single-port synchronous RAM, read-first, parameterised on width and address bits.
  - It is instantiated twice: dmem at 8 bits, imem at 16 bits.
  - Its port mux (loader / core / dump) lives in `mem_responder`.

## Test plan
- **Load then read**:
  - Load imem[0]=16'h1234 and dmem[5]=8'hA5, with `ld_last` on the second beat.
  - Then `status`=01.
  - With `pc_out`=0 and `dar_out`=5, next cycle `im_out`=16'h1234 and `dm_out`=8'hA5.
- **Core write, read-first**:
  - In RUN, `dm_en`=1, `dar_out`=5, `bus_out`=16'h003C.
  - The same-cycle read returns A5; the following cycle returns 3C.
- **Address wrap**: `dar_out`=16'h0105 with DM_AW=8 accesses address 5.
- **Dump with stalls**:
  - `end_process` while a write to dmem[0]=8'h77 is pending.
  - First beat: `dump_addr`=0, `dump_data`=77.
  - Hold `dump_ready`=0 for 3 cycles: data stays stable.
  - Last beat at 255 has `dump_last`=1, then `status`=11.
- **Ignored inputs**:
  - `end_process` in LOAD: no change.
  - `ld_valid` in RUN: no memory change and `ld_ready`=0.
- **Reset mid-dump**:
  - `rst` during SHOW of beat 10.
  - Next cycle: `status`=00, `dump_valid`=0, `ld_ready`=1.
  - Memory is preserved: re-run and dump shows the same bytes.
